// File: rtl/btn_event_decoder.sv
// Button event decoder: turns a debounced button level into short-press,
// long-press and auto-repeat pulses plus a held status flag.
module btn_event_decoder #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic CLK100HZ,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESS,
        HOLD
    } state_e;

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            WAIT_REL: begin
                if (!btn_level) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (btn_level) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS: begin
                if (!btn_level) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_M1) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                // Release beats a coincident repeat: no pulse on that edge.
                if (!btn_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == REP_M1)) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESS) || (state_d == HOLD);
    end

    always_ff @(posedge CLK100HZ) begin
        if (!rst_n) begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign held         = held_q;

endmodule
